qmult_seq_ctrl: RTL and testbench

Sequencing controller and datapath for a multi-cycle signed fixed-point multiplier in the qpoint sign-magnitude format.
- Operand format: bit N-1 is the sign; bits N-2:0 are the magnitude with Q fractional bits.
- Accepts one operand pair per valid/ready handshake and runs an (N-1)-cycle shift-add loop over the magnitudes.
- Truncates (or rounds) back to Q fractional bits, reapplies the sign, and flags and saturates on overflow.
- Sits between the qpoint arithmetic front end and consumers that cannot afford a full combinational multiplier.

---
 rtl/qpoint_pkg.sv | 26 ++
 rtl/q_shift_add_core.sv | 66 ++++++
 rtl/qmult_seq_ctrl.sv | 101 ++++++++++
 tb/tb_qmult_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpoint_pkg.sv
// qpoint_pkg: shared definitions for the qpoint sequential multiplier.
//   Provides the default Q/N widths, the controller state encoding and the
//   width helpers MAG_W = N-1 (magnitude) and ACC_W = 2N-2 (full product).
package qpoint_pkg;

    localparam int Q_DEF     = 15;
    localparam int N_DEF     = 32;
    localparam int MAG_W_DEF = N_DEF - 1;
    localparam int ACC_W_DEF = 2 * N_DEF - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int mag_w(input int n);
        return n - 1;
    endfunction

    function automatic int acc_w(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/q_shift_add_core.sv
// q_shift_add_core: magnitude shift-add engine for the qpoint multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : abandon the current product (counter drained)
//   load       : latch a_mag/b_mag, clear the accumulator, arm N-1 iterations
//   step       : perform one shift-add iteration while iterations remain
//   a_mag      : multiplicand magnitude
//   b_mag      : multiplier magnitude
//   prod       : acc[ACC_W-1:Q] plus the optional rounding increment,
//                one bit wider so a rounding carry is visible
//   done       : no iterations left
module q_shift_add_core
    import qpoint_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int Q   = Q_DEF,
    parameter bit RND = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             step,
    input  logic [N-2:0]     a_mag,
    input  logic [N-2:0]     b_mag,
    output logic [2*N-2-Q:0] prod,
    output logic             done
);

    localparam int MAG_W = mag_w(N);
    localparam int ACC_W = acc_w(N);
    localparam int CNT_W = $clog2(N);
    localparam int PRD_W = ACC_W - Q + 1;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mcand;
    logic [MAG_W-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    assign done = cnt == '0;

    // Round half up on the magnitude: bit Q-1 is the first discarded bit.
    assign prod = {1'b0, acc[ACC_W-1:Q]} + PRD_W'(RND & acc[Q-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (clr) begin
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{(ACC_W-MAG_W){1'b0}}, a_mag};
            mplier <= b_mag;
            cnt    <= CNT_W'(MAG_W);
        end else if (step && !done) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/qmult_seq_ctrl.sv
// qmult_seq_ctrl: sequential sign-magnitude fixed-point multiplier controller.
//   Optional build macro QMULT_ROUND_EN: round half up instead of truncating.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : synchronous abort back to IDLE, pending result dropped
//   i_valid/o_ready: operand handshake, i_a/i_b sampled on the accepting edge
//   o_valid/i_ready: result handshake, o_result/o_ovf held while waiting
//   o_busy         : high outside IDLE
module qmult_seq_ctrl
    import qpoint_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_ovf,
    output logic         o_busy
);

    localparam int MAG_W = mag_w(N);

`ifdef QMULT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    state_t           state;
    state_t           state_nxt;
    logic             sign;
    logic             accept;
    logic             core_done;
    logic             ovf;
    logic [2*N-2-Q:0] prod;
    logic [MAG_W-1:0] mag;

    assign accept  = state == IDLE && i_valid && !i_flush;
    assign o_ready = state == IDLE;
    assign o_busy  = state != IDLE;
    assign o_valid = state == DONE;

    // Anything above the magnitude field, including a rounding carry, overflows.
    assign ovf = |prod[2*N-2-Q:MAG_W];
    assign mag = ovf ? '1 : prod[MAG_W-1:0];

    // MULT is left only once the iteration counter has drained, which fixes
    // the latency at N+1 edges regardless of operand values.
    always_comb begin
        state_nxt = i_flush          ? IDLE :
                    state == IDLE    ? (i_valid ? MULT : IDLE) :
                    state == MULT    ? (core_done ? FIX : MULT) :
                    state == FIX     ? DONE :
                    i_ready          ? IDLE : DONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            sign     <= 1'b0;
            o_result <= '0;
            o_ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                sign <= i_a[N-1] ^ i_b[N-1];
            if (i_flush) begin
                o_result <= '0;
                o_ovf    <= 1'b0;
            end else if (state == FIX) begin
                // A zero magnitude never carries a negative sign.
                o_result <= {sign & |mag, mag};
                o_ovf    <= ovf;
            end
        end
    end

    q_shift_add_core #(
        .N   (N),
        .Q   (Q),
        .RND (RND)
    ) u_core (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_flush),
        .load  (accept),
        .step  (state == MULT),
        .a_mag (i_a[N-2:0]),
        .b_mag (i_b[N-2:0]),
        .prod  (prod),
        .done  (core_done)
    );

endmodule

// File: tb/tb_qmult_seq_ctrl.sv
// tb_qmult_seq_ctrl: directed and reference-model bench for qmult_seq_ctrl.
module tb_qmult_seq_ctrl;

`ifdef QMULT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        ovf;
    logic        busy;

    logic        flush8;
    logic        v8;
    logic        rdy8_o;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        vld8_o;
    logic        rdy8_i;
    logic [7:0]  res8;
    logic        ovf8;
    logic        busy8;

    int tests = 0;
    int fails = 0;

    qmult_seq_ctrl #(.Q(15), .N(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_flush  (flush),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_a      (a),
        .i_b      (b),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_result (result),
        .o_ovf    (ovf),
        .o_busy   (busy)
    );

    qmult_seq_ctrl #(.Q(4), .N(8)) dut8 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_flush  (flush8),
        .i_valid  (v8),
        .o_ready  (rdy8_o),
        .i_a      (a8),
        .i_b      (b8),
        .o_valid  (vld8_o),
        .i_ready  (rdy8_i),
        .o_result (res8),
        .o_ovf    (ovf8),
        .o_busy   (busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one operation on the 32-bit DUT from IDLE and wait for o_valid.
    task automatic op32(input logic [31:0] ta, input logic [31:0] tb,
                        output logic [31:0] r, output logic o, output int lat);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        o = ovf;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                       output logic [7:0] r, output logic o, output int lat);
        v8 = 1'b1;
        a8 = ta;
        b8 = tb;
        @(posedge clk); #1;
        v8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 0;
        while (!vld8_o && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res8;
        o = ovf8;
    endtask

    // Arithmetic reference for N=8, Q=4: returns {ovf, result}.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
        int p;
        int m;
        logic s;
        p = int'(x[6:0]) * int'(y[6:0]);
        m = (p >> 4) + (RND ? ((p >> 3) & 1) : 0);
        s = x[7] ^ y[7];
        if (m > 127)
            return {1'b1, s, 7'h7f};
        return {1'b0, s && (m != 0), 7'(m)};
    endfunction

    vec_t        vecs[11];
    logic [31:0] r;
    logic        o;
    logic [7:0]  r8;
    logic        o8;
    logic [8:0]  e8;
    int          lat;
    logic        seen;

    initial begin
        vecs[0]  = '{32'h0000C000, 32'h80010000, 32'h80018000, 1'b0};
        vecs[1]  = '{32'h80000000, 32'h00008000, 32'h00000000, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1};
        vecs[3]  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{32'h00000001, 32'h00004000, {31'b0, RND}, 1'b0};
        vecs[5]  = '{32'h00000003, 32'h00004000, RND ? 32'h2 : 32'h1, 1'b0};
        vecs[6]  = '{32'h00018000, 32'h80008000, 32'h80018000, 1'b0};
        vecs[7]  = '{32'h80000001, 32'h00000001, 32'h00000000, 1'b0};
        vecs[8]  = '{32'h40000000, 32'h00010000, 32'h7FFFFFFF, 1'b1};
        vecs[9]  = '{32'h3FFFFFFF, 32'h00010000, 32'h7FFFFFFE, 1'b0};
        vecs[10] = '{32'h80004000, 32'h80004000, 32'h00002000, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; in_ready = 1'b1;
        flush8 = 1'b0; v8 = 1'b0; a8 = '0; b8 = '0; rdy8_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", out_ready, 1);
        check("reset valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset ovf", ovf, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            op32(vecs[i].a, vecs[i].b, r, o, lat);
            check($sformatf("vec%0d latency", i), lat, 33);
            check($sformatf("vec%0d result", i), r, vecs[i].res);
            check($sformatf("vec%0d ovf", i), o, vecs[i].ovf);
            @(posedge clk); #1;
            check($sformatf("vec%0d ready after handshake", i), out_ready, 1);
            check($sformatf("vec%0d valid dropped", i), out_valid, 0);
        end

        // Consumer stalls in DONE while the producer side churns.
        in_ready = 1'b0;
        op32(32'h0000C000, 32'h80010000, r, o, lat);
        check("stall latency", lat, 33);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom);
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
            check($sformatf("stall%0d result", k), result, 32'h80018000);
            check($sformatf("stall%0d ovf", k), ovf, 0);
            check($sformatf("stall%0d ready", k), out_ready, 0);
            check($sformatf("stall%0d valid", k), out_valid, 1);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(posedge clk); #1;
        check("stall release valid", out_valid, 0);
        check("stall release busy", busy, 0);

        // Asynchronous reset in the middle of MULT.
        in_valid = 1'b1; a = 32'h7FFFFFFF; b = 32'h7FFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst ready", out_ready, 1);
        check("async rst valid", out_valid, 0);
        check("async rst result", result, 0);
        check("async rst ovf", ovf, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        op32(32'h0000C000, 32'h80010000, r, o, lat);
        check("post rst latency", lat, 33);
        check("post rst result", r, 32'h80018000);
        @(posedge clk); #1;

        // Flush on the tenth MULT cycle.
        in_valid = 1'b1; a = 32'h00018000; b = 32'h00018000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre flush busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush ready", out_ready, 1);
        check("flush valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush no result", seen, 0);

        // Flush wins over a same-edge accept.
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush blocks accept", busy, 0);
        op32(32'h80004000, 32'h80004000, r, o, lat);
        check("post flush result", r, 32'h00002000);
        check("post flush ovf", o, 0);
        @(posedge clk); #1;

        // Narrow instance against the arithmetic reference.
        for (int k = 0; k < 24; k++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = (k == 0) ? 8'h7F : (k == 1) ? 8'hFF : 8'($urandom);
            y = (k < 2) ? 8'h7F : 8'($urandom);
            e8 = model8(x, y);
            op8(x, y, r8, o8, lat);
            check($sformatf("n8 op%0d latency", k), lat, 9);
            check($sformatf("n8 op%0d %0h*%0h result", k, x, y), r8, e8[7:0]);
            check($sformatf("n8 op%0d ovf", k), o8, e8[8]);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
